// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: board geometry, empty-cell value and
// the lock_piece state encodings.
package tetris_pkg;

    localparam int BOARD_W     = 10;
    localparam int BOARD_H     = 24;
    localparam int HIDDEN_ROWS = 4;

    localparam logic [5:0] EMPTY    = 6'b0;
    localparam logic [3:0] LAST_COL = 4'(BOARD_W - 1);
    localparam logic [4:0] LAST_ROW = 5'(BOARD_H - 1);
    localparam logic [3:0] SCAN_END = 4'(BOARD_W);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_SCAN      = 3'd2,
        S_SHIFT     = 3'd3,
        S_CLEAR_TOP = 3'd4,
        S_DONE      = 3'd5
    } lp_state_t;

    function automatic logic [1:0] cell_off(
        input logic [7:0] c,
        input logic [1:0] k
    );
        return c[{k, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/board_addr.sv
// Maps a board cell (x, y) to its linear RAM address y*10 + x.
module board_addr
    import tetris_pkg::*;
(
    input  logic [3:0] x,
    input  logic [4:0] y,
    output logic [7:0] addr
);

    assign addr = {3'b0, y} * 8'(BOARD_W) + {4'b0, x};

endmodule

// File: rtl/lock_piece.sv
// Commits a falling piece to the board RAM, then scans bottom-up and
// removes every full row, shifting the rows above it down by one.
module lock_piece
    import tetris_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] X_in,
    input  logic [5:0] Y_in,
    input  logic [7:0] coord_x,
    input  logic [7:0] coord_y,
    input  logic [5:0] colour,
    input  logic [5:0] ram_Q,
    output logic [7:0] ram_addr,
    output logic [5:0] ram_data,
    output logic       ram_wren,
    output logic       busy,
    output logic       done,
    output logic [2:0] lines_cleared
);

    lp_state_t  state_q, state_d;
    logic [4:0] x_q, x_d;
    logic [5:0] y_q, y_d;
    logic [7:0] cx_q, cx_d;
    logic [7:0] cy_q, cy_d;
    logic [5:0] col_q, col_d;
    logic [2:0] lines_q, lines_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] row_q, row_d;
    logic [4:0] j_q, j_d;
    logic       wr_ph_q, wr_ph_d;
    logic       full_q, full_d;

    logic [5:0] cell_x;
    logic [6:0] cell_y;
    logic       cell_ok;
    logic       q_nz;
    logic       row_full;
    logic [3:0] ax;
    logic [4:0] ay;

    board_addr u_addr (
        .x    (ax),
        .y    (ay),
        .addr (ram_addr)
    );

    assign cell_x = {1'b0, x_q} + {4'b0, cell_off(cx_q, cnt_q[1:0])};
    assign cell_y = {1'b0, y_q} + {5'b0, cell_off(cy_q, cnt_q[1:0])};
    assign cell_ok = (cell_x <= {2'b0, LAST_COL})
                  && (cell_y <= {2'b0, LAST_ROW});
    assign q_nz = (ram_Q != EMPTY);

    assign busy = (state_q != S_IDLE);
    assign lines_cleared = lines_q;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        col_d    = col_q;
        lines_d  = lines_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        j_d      = j_q;
        wr_ph_d  = wr_ph_q;
        full_d   = full_q;
        ax       = '0;
        ay       = '0;
        ram_wren = 1'b0;
        ram_data = EMPTY;
        done     = 1'b0;
        row_full = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = X_in;
                    y_d     = Y_in;
                    cx_d    = coord_x;
                    cy_d    = coord_y;
                    col_d   = colour;
                    lines_d = '0;
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                ram_data = col_q;
                if (cell_ok) begin
                    ax       = cell_x[3:0];
                    ay       = cell_y[4:0];
                    ram_wren = 1'b1;
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd3) begin
                    cnt_d   = '0;
                    full_d  = 1'b1;
                    row_d   = LAST_ROW;
                    state_d = (col_q == EMPTY) ? S_DONE : S_SCAN;
                end
            end

            // Addresses go out on cnt 0..9; read data lands on cnt 1..10.
            S_SCAN: begin
                ay = row_q;
                ax = (cnt_q <= LAST_COL) ? cnt_q : 4'd0;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q != 4'd0) begin
                    full_d = full_q && q_nz;
                end
                if (cnt_q == SCAN_END) begin
                    row_full = full_q && q_nz;
                    cnt_d    = '0;
                    full_d   = 1'b1;
                    if (row_full) begin
                        if (lines_q != 3'd7) begin
                            lines_d = lines_q + 3'd1;
                        end
                        j_d     = row_q;
                        wr_ph_d = 1'b0;
                        state_d = (row_q == 5'd0) ? S_CLEAR_TOP : S_SHIFT;
                    end else if (row_q == 5'd0) begin
                        state_d = S_DONE;
                    end else begin
                        row_d = row_q - 5'd1;
                    end
                end
            end

            S_SHIFT: begin
                ax = cnt_q;
                if (!wr_ph_q) begin
                    ay      = j_q - 5'd1;
                    wr_ph_d = 1'b1;
                end else begin
                    ay       = j_q;
                    ram_data = ram_Q;
                    ram_wren = 1'b1;
                    wr_ph_d  = 1'b0;
                    cnt_d    = cnt_q + 4'd1;
                    if (cnt_q == LAST_COL) begin
                        cnt_d = '0;
                        if (j_q == 5'd1) begin
                            state_d = S_CLEAR_TOP;
                        end else begin
                            j_d = j_q - 5'd1;
                        end
                    end
                end
            end

            S_CLEAR_TOP: begin
                ax       = cnt_q;
                ram_wren = 1'b1;
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == LAST_COL) begin
                    cnt_d   = '0;
                    full_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= '0;
            lines_q <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            j_q     <= '0;
            wr_ph_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            col_q   <= col_d;
            lines_q <= lines_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            j_q     <= j_d;
            wr_ph_q <= wr_ph_d;
            full_q  <= full_d;
        end
    end

endmodule

// File: tb/tb_lock_piece.sv
// Bench for lock_piece: behavioural board RAM, directed vectors,
// reset corner cases and random boards checked against a row-level model.
module tb_lock_piece;
    import tetris_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] X_in;
    logic [5:0] Y_in;
    logic [7:0] coord_x;
    logic [7:0] coord_y;
    logic [5:0] colour;
    logic [5:0] ram_Q;
    logic [7:0] ram_addr;
    logic [5:0] ram_data;
    logic       ram_wren;
    logic       busy;
    logic       done;
    logic [2:0] lines_cleared;

    always #5 clk = ~clk;

    lock_piece dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .X_in          (X_in),
        .Y_in          (Y_in),
        .coord_x       (coord_x),
        .coord_y       (coord_y),
        .colour        (colour),
        .ram_Q         (ram_Q),
        .ram_addr      (ram_addr),
        .ram_data      (ram_data),
        .ram_wren      (ram_wren),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared)
    );

    logic [5:0] mem [240];
    logic [5:0] img [240];
    logic [5:0] mdl [240];
    logic       load;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 240; i++) mem[i] <= img[i];
        end else if (ram_wren && ram_addr < 8'd240) begin
            mem[ram_addr] <= ram_data;
        end
        ram_Q <= (ram_addr < 8'd240) ? mem[ram_addr] : 6'd0;
    end

    typedef struct {
        int         brd;
        logic [4:0] x;
        logic [5:0] y;
        logic [7:0] cx;
        logic [7:0] cy;
        logic [5:0] col;
        int         lines;
        int         nwr;
    } vec_t;

    vec_t tbl [7];

    int n_pass = 0;
    int n_tot  = 0;
    int exp_wa [$];
    int exp_wd [$];
    int got_wa [$];
    int got_wd [$];
    int exp_lines;
    int done_cyc;
    int busy_gap;
    int last_addr;
    int last_wren;
    int after_done;
    int after_busy;

    task automatic check(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic make_board(input int id);
        for (int i = 0; i < 240; i++) img[i] = 6'd0;
        case (id)
            1: begin
                for (int x = 0; x < 9; x++) img[230 + x] = 6'(x + 1);
                for (int x = 0; x < 10; x += 2) img[220 + x] = 6'd5;
            end
            2: begin
                for (int r = 20; r < 24; r++)
                    for (int x = 1; x < 10; x++)
                        img[r * 10 + x] = 6'((r * 3 + x) % 63 + 1);
                for (int r = 16; r < 20; r++)
                    for (int x = 0; x < 10; x++)
                        if ((x + r) % 3 == 0) img[r * 10 + x] = 6'(10 + r);
            end
            4: begin
                for (int r = 16; r < 24; r++)
                    for (int x = 0; x < 10; x++)
                        img[r * 10 + x] = 6'((r + x) % 60 + 1);
            end
            default: ;
        endcase
    endtask

    task automatic random_board();
        for (int i = 0; i < 240; i++) img[i] = 6'd0;
        for (int r = HIDDEN_ROWS; r < BOARD_H; r++) begin
            if ($urandom % 4 == 0) begin
                int hole = ($urandom % 2 == 0) ? -1 : int'($urandom_range(0, 9));
                for (int x = 0; x < BOARD_W; x++)
                    if (x != hole) img[r * 10 + x] = 6'($urandom_range(1, 63));
            end else begin
                for (int x = 0; x < BOARD_W; x++)
                    if ($urandom % 2 == 0) img[r * 10 + x] = 6'($urandom_range(1, 63));
            end
        end
    endtask

    task automatic load_board();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 240; i++) mdl[i] = img[i];
    endtask

    // Reference: place the piece, then drop full rows bottom-up.
    task automatic model_op(input logic [4:0] x, input logic [5:0] y,
                            input logic [7:0] cx, input logic [7:0] cy,
                            input logic [5:0] col);
        int r;
        bit full;
        exp_wa.delete();
        exp_wd.delete();
        exp_lines = 0;
        for (int k = 0; k < 4; k++) begin
            int px = int'(x) + int'((cx >> (2 * k)) & 8'd3);
            int py = int'(y) + int'((cy >> (2 * k)) & 8'd3);
            if (px < BOARD_W && py < BOARD_H) begin
                mdl[py * 10 + px] = col;
                exp_wa.push_back(py * 10 + px);
                exp_wd.push_back(int'(col));
            end
        end
        if (col == 6'd0) return;
        r = BOARD_H - 1;
        while (1) begin
            full = 1'b1;
            for (int c = 0; c < BOARD_W; c++)
                if (mdl[r * 10 + c] == 6'd0) full = 1'b0;
            if (full) begin
                if (exp_lines < 7) exp_lines++;
                for (int j = r; j > 0; j--)
                    for (int c = 0; c < BOARD_W; c++)
                        mdl[j * 10 + c] = mdl[(j - 1) * 10 + c];
                for (int c = 0; c < BOARD_W; c++) mdl[c] = 6'd0;
            end else if (r == 0) begin
                break;
            end else begin
                r--;
            end
        end
    endtask

    task automatic run_op(input logic [4:0] x, input logic [5:0] y,
                          input logic [7:0] cx, input logic [7:0] cy,
                          input logic [5:0] col, input bit poke);
        int pa;
        int pw;
        got_wa.delete();
        got_wd.delete();
        done_cyc = -1;
        busy_gap = 0;
        pa = 0;
        pw = 0;
        @(negedge clk);
        X_in = x; Y_in = y; coord_x = cx; coord_y = cy; colour = col;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 15000; cyc++) begin
            if (ram_wren && cyc < 4) begin
                got_wa.push_back(int'(ram_addr));
                got_wd.push_back(int'(ram_data));
            end
            if (!busy) busy_gap++;
            if (done) begin
                done_cyc  = cyc;
                last_addr = pa;
                last_wren = pw;
                break;
            end
            pa = int'(ram_addr);
            pw = int'(ram_wren);
            if (poke && cyc == 6) begin
                start = 1'b1;
                X_in = 5'd0; Y_in = 6'd0;
                coord_x = 8'd0; coord_y = 8'd0; colour = 6'h3F;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        after_done = int'(done);
        after_busy = int'(busy);
    endtask

    task automatic verify_op(input string tag, input int lines_exp,
                             input logic [5:0] col);
        int mism;
        int n;
        check({tag, " done_seen"}, int'(done_cyc >= 0), 1);
        check({tag, " lines"}, int'(lines_cleared), lines_exp);
        check({tag, " nwr"}, got_wa.size(), exp_wa.size());
        n = (got_wa.size() < exp_wa.size()) ? got_wa.size() : exp_wa.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " wr_addr"}, got_wa[i], exp_wa[i]);
            check({tag, " wr_data"}, got_wd[i], exp_wd[i]);
        end
        mism = 0;
        for (int i = 0; i < 240; i++) if (mem[i] !== mdl[i]) mism++;
        check({tag, " board_mism"}, mism, 0);
        check({tag, " busy_gap"}, busy_gap, 0);
        check({tag, " done_pulse"}, after_done, 0);
        check({tag, " busy_after"}, after_busy, 0);
        if (col == 6'd0)
            check({tag, " done_cyc"}, done_cyc, 4);
        else
            check({tag, " done_after_row0"},
                  int'(done_cyc > 4 && last_addr < 10 && last_wren == 0), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int found;
        tbl[0] = '{0, 5'd4, 6'd10, 8'b00011011, 8'd0, 6'h0C, 0, 4};
        tbl[1] = '{1, 5'd9, 6'd20, 8'd0, 8'b11100100, 6'h0C, 1, 4};
        tbl[2] = '{2, 5'd0, 6'd20, 8'd0, 8'b11100100, 6'h07, 4, 4};
        tbl[3] = '{0, 5'd9, 6'd5, 8'b00001000, 8'b11100100, 6'h11, 0, 3};
        tbl[4] = '{1, 5'd2, 6'd23, 8'b00011011, 8'd0, 6'h00, 0, 4};
        tbl[5] = '{0, 5'd0, 6'd22, 8'd0, 8'b11100100, 6'h21, 0, 2};
        tbl[6] = '{4, 5'd0, 6'd0, 8'b00011011, 8'd0, 6'h03, 7, 4};

        reset = 1'b1; start = 1'b0; load = 1'b0;
        X_in = '0; Y_in = '0; coord_x = '0; coord_y = '0; colour = '0;
        repeat (2) @(negedge clk);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst wren", int'(ram_wren), 0);
        check("rst addr", int'(ram_addr), 0);
        check("rst data", int'(ram_data), 0);
        check("rst lines", int'(lines_cleared), 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            make_board(tbl[i].brd);
            load_board();
            model_op(tbl[i].x, tbl[i].y, tbl[i].cx, tbl[i].cy, tbl[i].col);
            run_op(tbl[i].x, tbl[i].y, tbl[i].cx, tbl[i].cy, tbl[i].col, i == 0);
            verify_op(tag, tbl[i].lines, tbl[i].col);
            check({tag, " nwr_tbl"}, got_wa.size(), tbl[i].nwr);
        end

        // Reset in the middle of a row shift.
        make_board(1);
        load_board();
        @(negedge clk);
        X_in = 5'd9; Y_in = 6'd20; coord_x = 8'd0;
        coord_y = 8'b11100100; colour = 6'h0C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc >= 4 && ram_wren) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("mid shift reached", found, 1);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst busy", int'(busy), 0);
        check("midrst wren", int'(ram_wren), 0);
        check("midrst done", int'(done), 0);
        check("midrst lines", int'(lines_cleared), 0);
        X_in = 5'd0; Y_in = 6'd0; coord_x = 8'b00011011;
        coord_y = 8'd0; colour = 6'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart busy", int'(busy), 1);
        check("restart wren", int'(ram_wren), 1);
        check("restart addr", int'(ram_addr), 3);
        found = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (done) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("restart done", found, 1);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        colour = 6'h05;
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_pri busy", int'(busy), 0);
        check("rst_pri wren", int'(ram_wren), 0);
        @(negedge clk);
        check("rst_pri busy2", int'(busy), 0);

        for (int t = 0; t < 20; t++) begin
            logic [4:0] rx;
            logic [5:0] ry;
            logic [7:0] rcx;
            logic [7:0] rcy;
            logic [5:0] rcol;
            rx   = 5'($urandom_range(0, 11));
            ry   = 6'($urandom_range(0, 23));
            rcx  = 8'($urandom);
            rcy  = 8'($urandom);
            rcol = ($urandom % 8 == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            random_board();
            load_board();
            model_op(rx, ry, rcx, rcy, rcol);
            run_op(rx, ry, rcx, rcy, rcol, 1'b0);
            verify_op($sformatf("rnd%0d", t), exp_lines, rcol);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/lock_piece.md
LOCK_PIECE -- requirements
Module: lock_piece

Interface
REQ-001 SHALL provide clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL provide reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL provide start, input, 1 bit: one-cycle request to commit the current piece; sampled only in IDLE.
REQ-004 SHALL provide X_in, input, 5 bits, and Y_in, input, 6 bits: piece anchor in board cells.
REQ-005 SHALL provide coord_x and coord_y, inputs, 8 bits each: four 2-bit cell offsets, cell k at bits [2k+1:2k].
REQ-006 SHALL provide colour, input, 6 bits: piece colour; 0 means empty.
REQ-007 SHALL provide ram_Q, input, 6 bits: board RAM read data.
REQ-008 SHALL provide ram_addr, output, 8 bits: board RAM address.
REQ-009 SHALL provide ram_data, output, 6 bits: board RAM write data.
REQ-010 SHALL provide ram_wren, output, 1 bit: board RAM write enable.
REQ-011 SHALL provide busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL provide done, output, 1 bit: one-cycle pulse when the operation completes.
REQ-013 SHALL provide lines_cleared, output, 3 bits: count of rows removed by the last operation; held until the next start.

Function
REQ-014 SHALL model the board as 10 columns (x 0-9) by 24 rows (y 0-23, rows 0-3 hidden), with address = y*10 + x.
REQ-015 SHALL assume a RAM read latency of 1 cycle: an address driven in cycle n yields ram_Q in cycle n+1.
REQ-016 SHALL implement the states IDLE, WRITE, SCAN, SHIFT, CLEAR_TOP and DONE.
REQ-017 SHALL, in IDLE, on start=1, latch X_in, Y_in, coord_x, coord_y and colour, clear lines_cleared, and go to WRITE.
REQ-018 SHALL, in WRITE, spend exactly 4 cycles, cell k=0..3, writing colour at (X+offx_k, Y+offy_k) with ram_wren=1.
REQ-019 SHALL suppress ram_wren for any WRITE cell with x>9 or y>23; the cycle is still consumed.
REQ-020 SHALL go from WRITE to DONE when the latched colour is 0, and to SCAN starting at row 23 otherwise.
REQ-021 SHALL, in SCAN, read the 10 cells of row r; the row is full when all 10 cells are nonzero.
REQ-022 SHALL, on a full row, increment lines_cleared and go to SHIFT; on a non-full row with r>0, move to r-1; on a non-full row with r=0, go to DONE.
REQ-023 SHALL, in SHIFT, for each row j from r down to 1 and each column x 0-9, read (x, j-1) and then write that value to (x, j), using 2 cycles per cell.
REQ-024 SHALL, after SHIFT, go to CLEAR_TOP, write 0 to row 0 over 10 cycles, and then re-scan the same row r.
REQ-025 SHALL saturate lines_cleared at 7.
REQ-026 SHALL, in DONE, assert done for exactly 1 cycle and then return to IDLE.
REQ-027 SHALL hold ram_wren=0 in IDLE, SCAN and DONE, and during the read cycles of SHIFT.
REQ-028 SHALL ignore start while busy=1.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, enter IDLE with ram_wren=0, busy=0, done=0, lines_cleared=0, ram_addr=0 and ram_data=0.
REQ-030 SHALL, on reset in the middle of an operation, abandon the operation with no further writes; a partially shifted board is accepted.
REQ-031 SHALL give reset priority over start in the same cycle.

Structure
REQ-032 SHALL place BOARD_W=10, BOARD_H=24, HIDDEN_ROWS=4, EMPTY=6'b0 and the state encodings in the shared tetris package.
REQ-033 SHALL implement the y*10+x address computation in a single sub-module, board_addr, instantiated once.

Verification
REQ-034 SHALL test an empty board, X=4, Y=10, coord_x=8'b00011011, coord_y=0, colour=6'h0C -> writes to addresses 104-107, lines_cleared=0, and done 1 cycle after the scan of row 0 ends.
REQ-035 SHALL test row 23 holding 9 cells with x=9 empty, and a piece filling (9,23) -> row 23 cleared, row 22 contents moved to row 23, row 0 zeroed, lines_cleared=1.
REQ-036 SHALL test rows 20-23 full except column 0, and an I piece vertical at x=0 -> lines_cleared=4 and rows 20-23 hold the former rows 16-19.
REQ-037 SHALL test X=9 with offset 2 -> no write for that cell (x=11) and all other cells written.
REQ-038 SHALL test colour=0 -> 4 zero writes and then DONE with no SCAN cycles.
REQ-039 SHALL test reset asserted mid-SHIFT -> next cycle busy=0 and ram_wren=0, and a start 1 cycle later is accepted.
